// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: hazard detection and stall/flush/bubble control for an in-order pipeline
// with multi-cycle mul/div, data-memory wait states, a sticky memory timeout and a stall-cycle counter.
module pipeline_stall_controller #(
  parameter int MDU_LAT     = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadIDEX,
  input  logic [4:0]  rdIDEX,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic        mdu_start,
  input  logic        branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        PCWrite,
  output logic        IFIDwrite,
  output logic        IFIDflush,
  output logic        control_mux,
  output logic        IDEXwrite,
  output logic        EXMEMbubble,
  output logic        mem_hold,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles
);
  localparam logic [1:0]  RUN        = 2'd0;
  localparam logic [1:0]  MDU_BUSY   = 2'd1;
  localparam logic [1:0]  MEM_WAIT   = 2'd2;
  localparam logic [4:0]  MDU_INIT   = 5'(MDU_LAT >= 2 ? MDU_LAT - 2 : 0);
  localparam logic [10:0] TIMEOUT    = 11'(MEM_TIMEOUT);
  localparam bit          MDU_STALLS = (MDU_LAT >= 2);
  logic [1:0]  state, state_n;
  logic [4:0]  mdu_cnt;
  logic [9:0]  wait_cnt;
  logic [10:0] wait_run;
  logic        mem_stall, load_use, run_like, mdu_go, mdu_hold, mdu_stall, br, lu;
  assign mem_stall = dmem_req & ~dmem_ready;
  assign load_use  = MemReadIDEX && rdIDEX != 5'd0 && (rdIDEX == rs1 || rdIDEX == rs2);
  // MEM_WAIT shares RUN's decisions; mem_stall already outranks everything there
  assign run_like  = state != MDU_BUSY && !mem_stall;
  assign mdu_go    = run_like && mdu_start && MDU_STALLS;
  assign mdu_hold  = state == MDU_BUSY && mdu_cnt != 5'd0 && !mem_stall;
  assign mdu_stall = mdu_go || mdu_hold;
  assign br        = run_like && !mdu_go && branch_taken;
  assign lu        = run_like && !mdu_go && !branch_taken && load_use;
  assign wait_run  = {1'b0, wait_cnt} + 11'd1;
  always_comb begin
    PCWrite     = !reset && !(mem_stall || mdu_stall || lu);
    IFIDwrite   = PCWrite;
    IFIDflush   = reset || br;
    control_mux = !(reset || br || lu);
    IDEXwrite   = reset || !(mem_stall || mdu_stall);
    EXMEMbubble = reset || mdu_stall;
    mem_hold    = !reset && mem_stall;
    state_n     = state == MDU_BUSY ? (mdu_cnt != 5'd0 ? MDU_BUSY : mem_stall ? MEM_WAIT : RUN)
                : mem_stall ? MEM_WAIT : mdu_go ? MDU_BUSY : RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      mdu_cnt      <= 5'd0;
      wait_cnt     <= 10'd0;
      mem_timeout  <= 1'b0;
      stall_cycles <= 32'd0;
    end else begin
      state        <= state_n;
      mdu_cnt      <= mdu_go ? MDU_INIT : (state == MDU_BUSY && mdu_cnt != 5'd0) ? mdu_cnt - 5'd1 : mdu_cnt;
      wait_cnt     <= (state == MEM_WAIT && state_n == MEM_WAIT) ? (wait_cnt == 10'h3FF ? wait_cnt : wait_run[9:0]) : 10'd0;
      mem_timeout  <= mem_timeout || (state == MEM_WAIT && wait_run >= TIMEOUT);
      stall_cycles <= (!PCWrite && stall_cycles != 32'hFFFF_FFFF) ? stall_cycles + 32'd1 : stall_cycles;
    end
  end
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: table vectors, directed multi-cycle sequences and a randomized run
// against a behavioural model of the stall controller.
module tb_pipeline_stall_controller;
  localparam int MDU_LAT = 4;
  localparam int MEM_TIMEOUT = 255;
  localparam logic [6:0] NORM = 7'b1101100;
  localparam logic [6:0] LU   = 7'b0000100;
  localparam logic [6:0] BR   = 7'b1110100;
  localparam logic [6:0] MDU  = 7'b0001010;
  localparam logic [6:0] MEM  = 7'b0001001;
  localparam logic [6:0] RST  = 7'b0010110;
  logic clk = 1'b0, reset = 1'b1, MemReadIDEX = 1'b0, mdu_start = 1'b0, branch_taken = 1'b0;
  logic dmem_req = 1'b0, dmem_ready = 1'b0;
  logic [4:0] rdIDEX = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
  logic PCWrite, IFIDwrite, IFIDflush, control_mux, IDEXwrite, EXMEMbubble, mem_hold, mem_timeout;
  logic [31:0] stall_cycles;
  int vectors = 0, miscompares = 0;
  typedef struct {
    logic m; logic [4:0] rd; logic [4:0] a; logic [4:0] b;
    logic mdu; logic br; logic req; logic rdy; logic [6:0] exp;
  } vec_t;
  vec_t tbl[13];
  logic m_busy, m_wait, m_tmo, n_busy, n_wait, n_tmo;
  int m_owed, m_waited, n_owed, n_waited;
  logic [31:0] m_stalls, n_stalls;
  logic [6:0] exp_o;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.MDU_LAT(MDU_LAT), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .MemReadIDEX(MemReadIDEX), .rdIDEX(rdIDEX), .rs1(rs1), .rs2(rs2),
    .mdu_start(mdu_start), .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .PCWrite(PCWrite), .IFIDwrite(IFIDwrite), .IFIDflush(IFIDflush), .control_mux(control_mux),
    .IDEXwrite(IDEXwrite), .EXMEMbubble(EXMEMbubble), .mem_hold(mem_hold), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles)
  );

  function automatic logic [6:0] outs();
    return {PCWrite, IFIDwrite, IFIDflush, control_mux, IDEXwrite, EXMEMbubble, mem_hold};
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic m, input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b,
                       input logic mdu, input logic br, input logic req, input logic rdy);
    MemReadIDEX = m; rdIDEX = rd; rs1 = a; rs2 = b;
    mdu_start = mdu; branch_taken = br; dmem_req = req; dmem_ready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("reset_outs", 40'(outs()), 40'(RST));
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic cyc(input string name, input logic [6:0] exp);
    @(negedge clk);
    check(name, 40'(outs()), 40'(exp));
    next_cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic mem, acc, mstall, flush, lus, pc;
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, NORM};
    tbl[1]  = '{1, 5, 3, 5, 0, 0, 0, 0, LU};
    tbl[2]  = '{1, 0, 0, 0, 0, 0, 0, 0, NORM};
    tbl[3]  = '{1, 7, 7, 2, 0, 0, 0, 0, LU};
    tbl[4]  = '{0, 7, 7, 7, 0, 0, 0, 0, NORM};
    tbl[5]  = '{0, 0, 0, 0, 0, 1, 0, 0, BR};
    tbl[6]  = '{1, 5, 3, 5, 0, 1, 0, 0, BR};
    tbl[7]  = '{0, 0, 0, 0, 1, 0, 0, 0, MDU};
    tbl[8]  = '{1, 5, 5, 5, 1, 1, 0, 0, MDU};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 1, 0, MEM};
    tbl[10] = '{1, 9, 9, 1, 1, 1, 1, 0, MEM};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 1, 1, NORM};
    tbl[12] = '{0, 0, 0, 0, 0, 1, 0, 1, BR};
    next_cycle();
    do_reset();
    @(negedge clk);
    check("post_reset_stalls", {mem_timeout, stall_cycles}, 40'd0);
    next_cycle();
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].m, tbl[i].rd, tbl[i].a, tbl[i].b, tbl[i].mdu, tbl[i].br, tbl[i].req, tbl[i].rdy);
      cyc($sformatf("table[%0d]", i), tbl[i].exp);
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      next_cycle();
      reset = 1'b0;
    end
    // mul/div: MDU_LAT-1 stall cycles, then normal
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    cyc("mdu_c0", MDU);
    drive(1, 5, 5, 0, 0, 1, 0, 0);
    cyc("mdu_c1", MDU);
    cyc("mdu_c2", MDU);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("mdu_c3", 40'(outs()), 40'(NORM));
    check("mdu_stalls", 40'(stall_cycles), 40'd3);
    next_cycle();
    // long memory stall with timeout
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!mem_hold) bad++;
      if (i == 255) check("tmo_before", 40'(mem_timeout), 40'd0);
      if (i == 256) check("tmo_after", 40'(mem_timeout), 40'd1);
      next_cycle();
    end
    check("mem_hold_300", 40'(bad), 40'd0);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    check("mem_release", 40'(outs()), 40'(NORM));
    check("mem_stalls", 40'(stall_cycles), 40'd300);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("tmo_sticky", 40'(mem_timeout), 40'd1);
    next_cycle();
    do_reset();
    @(negedge clk);
    check("tmo_cleared", 40'(mem_timeout), 40'd0);
    next_cycle();
    // memory stall arriving during MDU_BUSY and outlasting it
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    cyc("mm_c0", MDU);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    cyc("mm_c1", MEM);
    cyc("mm_c2", MEM);
    cyc("mm_c3", MEM);
    cyc("mm_c4", MEM);
    drive(0, 0, 0, 0, 0, 1, 1, 1);
    @(negedge clk);
    check("mm_ready_as_run", 40'(outs()), 40'(BR));
    check("mm_stalls", 40'(stall_cycles), 40'd5);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc("mm_idle", NORM);
    // reset aborts MDU_BUSY
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    cyc("rb_c0", MDU);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rb_c1", MDU);
    reset = 1'b1;
    cyc("rb_reset", RST);
    reset = 1'b0;
    @(negedge clk);
    check("rb_after", {outs(), stall_cycles, mem_timeout}, {NORM, 32'd0, 1'b0});
    next_cycle();
    // randomized run against the behavioural model
    do_reset();
    m_busy = 0; m_wait = 0; m_tmo = 0; m_owed = 0; m_waited = 0; m_stalls = 0;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
      mem = dmem_req && !dmem_ready;
      acc = !m_busy && !mem && mdu_start && MDU_LAT >= 2;
      mstall = !mem && (acc || (m_busy && m_owed > 0));
      flush = !m_busy && !mem && !acc && branch_taken;
      lus = !m_busy && !mem && !acc && !branch_taken && MemReadIDEX && rdIDEX != 0 && (rdIDEX == rs1 || rdIDEX == rs2);
      pc = !(mem || mstall || lus);
      exp_o = reset ? RST : {pc, pc, flush, !(flush || lus), !(mem || mstall), mstall, mem};
      if (reset) begin
        n_busy = 0; n_wait = 0; n_tmo = 0; n_owed = 0; n_waited = 0; n_stalls = 0;
      end else begin
        n_tmo = m_tmo || (m_wait && m_waited + 1 >= MEM_TIMEOUT);
        n_stalls = (!pc && m_stalls != 32'hFFFF_FFFF) ? m_stalls + 1 : m_stalls;
        if (m_busy && m_owed > 0) begin
          n_busy = 1; n_owed = m_owed - 1; n_wait = 0;
        end else if (m_busy) begin
          n_busy = 0; n_owed = 0; n_wait = mem;
        end else begin
          n_busy = acc; n_owed = acc ? MDU_LAT - 2 : 0; n_wait = mem;
        end
        n_waited = (m_wait && n_wait) ? m_waited + 1 : 0;
      end
      @(negedge clk);
      check($sformatf("random[%0d]", i), {outs(), stall_cycles, mem_timeout}, {exp_o, m_stalls, m_tmo});
      m_busy = n_busy; m_wait = n_wait; m_tmo = n_tmo; m_owed = n_owed; m_waited = n_waited; m_stalls = n_stalls;
      next_cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter MDU_LAT, default 4, meaning multiply/divide EX latency in cycles (legal 1..16).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, meaning data-memory wait cycles before timeout flag (legal 1..1023).
REQ-003 SHALL have ports, clock and reset first:
  clk           in   1   sole clock, rising edge
  reset         in   1   synchronous, active-high
  MemReadIDEX   in   1   ID/EX instruction is a load
  rdIDEX        in   5   ID/EX destination register
  rs1, rs2      in   5   IF/ID source registers
  mdu_start     in   1   mul/div enters EX this cycle
  branch_taken  in   1   taken branch/jump resolved in EX
  dmem_req      in   1   MEM stage accesses data memory
  dmem_ready    in   1   data memory completes access this cycle
  PCWrite       out  1   1 = PC updates
  IFIDwrite     out  1   1 = IF/ID loads
  IFIDflush     out  1   1 = IF/ID loads a NOP
  control_mux   out  1   0 = zero control into ID/EX (bubble)
  IDEXwrite     out  1   1 = ID/EX loads
  EXMEMbubble   out  1   1 = zero control into EX/MEM
  mem_hold      out  1   1 = EX/MEM and MEM/WB hold
  mem_timeout   out  1   sticky memory-timeout flag
  stall_cycles  out  32  count of cycles with PCWrite=0

Function
REQ-004 SHALL implement states RUN, MDU_BUSY, MEM_WAIT; outputs combinational from state, counters and inputs; zero-cycle latency from hazard input to control output.
REQ-005 Normal outputs: PCWrite=1, IFIDwrite=1, IFIDflush=0, control_mux=1, IDEXwrite=1, EXMEMbubble=0, mem_hold=0.
REQ-006 mem_stall = dmem_req & !dmem_ready; in any state it SHALL have top priority: PCWrite=IFIDwrite=IDEXwrite=0, mem_hold=1, IFIDflush=0, control_mux=1, EXMEMbubble=0.
REQ-007 RUN, mdu_start, no mem_stall, MDU_LAT>=2: PCWrite=IFIDwrite=IDEXwrite=0, EXMEMbubble=1; load mdu_cnt=MDU_LAT-2; next MDU_BUSY.
REQ-008 MDU_LAT=1: mdu_start SHALL cause no stall and no state change.
REQ-009 MDU_BUSY: mdu_cnt decrements each cycle while nonzero, regardless of mem_stall; outputs as REQ-007 while mdu_cnt!=0 (unless mem_stall); at mdu_cnt=0 normal outputs and next RUN, or MEM_WAIT if mem_stall.
REQ-010 Total MDU stall SHALL equal MDU_LAT-1 cycles including the mdu_start cycle, absent mem_stall.
REQ-011 RUN, branch_taken, no mem_stall/mdu_start: IFIDflush=1, control_mux=0, PCWrite=1, IFIDwrite=1; single cycle; branch_taken wins over load-use.
REQ-012 RUN, load-use (MemReadIDEX & rdIDEX!=0 & (rdIDEX==rs1 | rdIDEX==rs2)), no higher-priority event: PCWrite=0, IFIDwrite=0, control_mux=0; else normal.
REQ-013 Priority in RUN: mem_stall > mdu_start > branch_taken > load-use; branch_taken and load-use SHALL be ignored in MDU_BUSY and under mem_stall.
REQ-014 RUN with mem_stall SHALL go to MEM_WAIT; MEM_WAIT with dmem_ready SHALL evaluate outputs and next state exactly as RUN.
REQ-015 wait_cnt (10 bit) SHALL count consecutive MEM_WAIT cycles, clear on exit; reaching MEM_TIMEOUT SHALL set mem_timeout, held until reset.
REQ-016 stall_cycles SHALL increment on each non-reset cycle with PCWrite=0, saturating at 0xFFFFFFFF.

Reset
REQ-017 reset sampled high SHALL set state=RUN, mdu_cnt=0, wait_cnt=0, mem_timeout=0, stall_cycles=0.
REQ-018 While reset high, outputs SHALL be PCWrite=0, IFIDwrite=0, IFIDflush=1, control_mux=0, IDEXwrite=1, EXMEMbubble=1, mem_hold=0.
REQ-019 reset mid-MDU_BUSY or mid-MEM_WAIT SHALL abort; first post-reset cycle in RUN.

Verification
REQ-020 MemReadIDEX=1, rdIDEX=5, rs2=5 -> PCWrite=0, IFIDwrite=0, control_mux=0 same cycle; rdIDEX=0 -> no stall.
REQ-021 MDU_LAT=4, mdu_start one cycle -> PCWrite=0 exactly 3 cycles, EXMEMbubble=1 those cycles, 4th normal; stall_cycles=3.
REQ-022 branch_taken with load-use hazard -> IFIDflush=1, control_mux=0, PCWrite=1 one cycle.
REQ-023 dmem_req=1, dmem_ready=0 for 300 cycles, MEM_TIMEOUT=255 -> mem_hold=1 throughout, mem_timeout set after 255 MEM_WAIT cycles, stays 1 after dmem_ready.
REQ-024 mdu_start then mem_stall during MDU_BUSY outlasting mdu_cnt -> mem_hold outputs, MEM_WAIT entry, normal outputs on dmem_ready.
REQ-025 reset pulse in MDU_BUSY -> REQ-018 outputs; next cycle normal, stall_cycles=0.
